// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder : single-outstanding data-memory responder with     |
// | programmable wait states, sub-word access and error detection.     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         c_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] c_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_idle;
   logic        w_exec;
   logic        w_we;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [1:0]  w_size;
   logic        w_unsigned;
   logic [1:0]  w_lane;
   logic [29:0] w_word_idx;
   logic [c_AW-1:0] w_idx;
   logic        w_err;
   logic [31:0] w_old;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_rdata;
   logic [31:0] w_new;
   logic        w_mem_we;

   assign w_idle = (r_state == S_IDLE);

   // With zero wait states the access runs on the accepting edge, so it
   // must use the live request fields rather than the latched copy.
   assign w_exec = (WAIT_CYCLES == 0) ? (w_idle & req_valid)
                                      : ((r_state == S_WAIT) && (r_cnt == c_LAST));

   assign w_we       = w_idle ? req_we       : r_we;
   assign w_addr     = w_idle ? req_addr     : r_addr;
   assign w_wdata    = w_idle ? req_wdata    : r_wdata;
   assign w_size     = w_idle ? req_size     : r_size;
   assign w_unsigned = w_idle ? req_unsigned : r_unsigned;

   assign w_lane     = w_addr[1:0];
   assign w_word_idx = w_addr[31:2];
   assign w_idx      = w_word_idx[c_AW-1:0];

   assign w_err = (w_size == 2'b11)
                | ((w_size == 2'b01) & w_lane[0])
                | ((w_size == 2'b10) & (|w_lane))
                | ({2'b00, w_word_idx} >= 32'(DEPTH_WORDS));

   assign w_old  = r_mem[w_idx];
   assign w_byte = w_old[{w_lane, 3'b000} +: 8];
   assign w_half = w_lane[1] ? w_old[31:16] : w_old[15:0];

   always_comb begin
      w_load = w_old;
      w_new  = w_old;
      case (w_size)
         2'b00: begin
            w_load = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            w_new[{w_lane, 3'b000} +: 8] = w_wdata[7:0];
         end
         2'b01: begin
            w_load = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            w_new[{w_lane[1], 4'b0000} +: 16] = w_wdata[15:0];
         end
         default: begin
            w_load = w_old;
            w_new  = w_wdata;
         end
      endcase
   end

   assign w_rdata  = (w_err | w_we) ? 32'd0 : w_load;
   // Reset gates the write so an aborted access can never reach memory.
   assign w_mem_we = w_exec & w_we & ~w_err & ~reset;

   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[w_idx] <= w_new;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_cnt      <= 4'd0;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: r_cnt <= r_cnt + 4'd1;
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
                  r_rdata <= 32'd0;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_exec) begin
            r_state <= S_RESP;
            r_rdata <= w_rdata;
            r_err   <= w_err;
         end
      end
   end

   assign req_ready = w_idle;
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the backing store.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request acceptance and response (0..15 legal).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned, out of range, or illegal size.

Function
REQ-016 FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-017 A request is accepted on a rising edge with req_valid & req_ready; req_we, req_addr, req_wdata, req_size and req_unsigned SHALL be latched at that edge and are don't-care afterwards.
REQ-018 On acceptance with WAIT_CYCLES=0, the access SHALL execute at the same edge and the FSM SHALL enter RESP.
REQ-019 On acceptance with WAIT_CYCLES>0, the FSM SHALL enter WAIT with the wait counter at 0.
REQ-020 In WAIT, the counter SHALL increment at each edge; at the edge where it equals WAIT_CYCLES-1, the access SHALL execute and the FSM SHALL enter RESP.
REQ-021 rsp_valid SHALL rise exactly WAIT_CYCLES+1 edges after the accepting edge is counted as edge 1 (i.e. visible after edge E0+WAIT_CYCLES).
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-023 A new request SHALL NOT be accepted on the same edge that retires a response; req_ready is 1 from the following cycle.
REQ-024 Word index = req_addr[31:2]; lane = req_addr[1:0].
REQ-025 Byte store writes req_wdata[7:0] to the selected lane only.
REQ-026 Halfword store writes req_wdata[15:0] to lanes {addr[1],0..1}.
REQ-027 Word store writes all 32 bits; unwritten lanes are unchanged.
REQ-028 Byte and halfword loads SHALL select the addressed lane(s) and extend to 32 bits per req_unsigned; word loads return the full word.
REQ-029 rsp_err SHALL be 1 for a halfword with addr[0]=1, a word with addr[1:0]!=0, req_size=11, or word index >= DEPTH_WORDS; memory SHALL NOT be modified and rsp_rdata SHALL be 0.
REQ-030 Stores SHALL return rsp_rdata=0 with rsp_err=0 on success.
REQ-031 Memory contents are not reset; a load from a never-written word returns X in simulation.

Reset
REQ-032 While reset is 1, the FSM SHALL be IDLE, the wait counter 0, and req_ready=1 (after release), rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-033 Reset asserted in WAIT SHALL abort the pending access; a store whose execute edge has not occurred SHALL NOT modify memory.
REQ-034 Reset asserted in RESP SHALL drop the response; committed stores remain in memory.

Verification
REQ-035 WAIT_CYCLES=2: word store of 0x0000_0019 to addr 0x64, rsp_ready=1 -> rsp_valid high after edge E0+2 for one cycle, rsp_err=0; a following word load of 0x64 returns 0x0000_0019.
REQ-036 Word 0x60 = 0x8000_80F0: a byte load of 0x60 (signed) returns 0xFFFF_FFF0; unsigned returns 0x0000_00F0; a signed half load of 0x62 returns 0xFFFF_8000.
REQ-037 Word 0x60 = 0x1122_3344: a byte store of 0xAB to 0x61, then a word load of 0x60 -> 0x1122_AB44; a half store of 0xBEEF to 0x62 -> 0xBEEF_AB44.
REQ-038 A word load of 0x66, a half load of 0x63, size 11, and a word load of 0x400 (DEPTH=256) -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0 throughout, with no second acceptance; FSM retires on the first rsp_ready=1 edge.
REQ-040 Store issued, reset pulsed one cycle after acceptance (WAIT_CYCLES=2) -> target word keeps its old value, rsp_valid never rises, and req_ready=1 after reset release.
